br_pred_unit: RTL

//  Parametrised branch unit: PC-indexed table of saturating counters predicts conditional

---
 rtl/br_pred_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/br_pred_unit.sv
// Branch prediction and resolution unit.
// The fetch side looks up a PC-indexed table of saturating counters.
// The execute side resolves conditional branches and JALR, trains the table,
// raises a one-cycle registered redirect and keeps two performance counters.
module br_pred_unit #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_ir,
  output logic            if_pr_taken,
  output logic [XLEN-1:0] if_pr_addr,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [31:0]     ex_ir,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_pr_taken,
  input  logic            stall,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_addr,
  output logic [31:0]     perf_br,
  output logic [31:0]     perf_miss
);

  localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  logic [CTR_BITS-1:0] ctr [BHT_ENTRIES];

  // Sign-extended B-type immediate
  function automatic logic [XLEN-1:0] b_imm(input logic [31:0] ir);
    return {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  // Sign-extended I-type immediate
  function automatic logic [XLEN-1:0] i_imm(input logic [31:0] ir);
    return {{(XLEN-12){ir[31]}}, ir[31:20]};
  endfunction

  // Fetch-side lookup (sees the table before any same-cycle update)
  logic [IDX_W-1:0] if_idx;
  logic             if_is_br;
  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_is_br    = (if_ir[6:0] == OP_BRANCH);
  assign if_pr_taken = if_is_br & ctr[if_idx][CTR_BITS-1];
  assign if_pr_addr  = if_pr_taken ? (if_pc + b_imm(if_ir)) : (if_pc + XLEN'(4));

  // Execute-side decode; anything behind a live redirect is wrong-path
  logic [IDX_W-1:0] ex_idx;
  logic [2:0]       ex_f3;
  logic             ex_fire;
  logic             ex_is_br;
  logic             ex_is_jalr;
  logic             ex_taken;
  logic             ex_miss;
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign ex_f3      = ex_ir[14:12];
  assign ex_fire    = ex_valid & ~stall & ~redir_valid;
  assign ex_is_jalr = (ex_ir[6:0] == OP_JALR);
  assign ex_is_br   = (ex_ir[6:0] == OP_BRANCH) & (ex_f3 != 3'b010) & (ex_f3 != 3'b011);
  assign ex_miss    = ex_is_br & (ex_taken != ex_pr_taken);

  // Branch condition evaluation by funct3
  always_comb begin
    ex_taken = 1'b0;
    case (ex_f3)
      3'b000:  ex_taken = (ex_rs1_data == ex_rs2_data);
      3'b001:  ex_taken = (ex_rs1_data != ex_rs2_data);
      3'b100:  ex_taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      3'b101:  ex_taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      3'b110:  ex_taken = (ex_rs1_data <  ex_rs2_data);
      3'b111:  ex_taken = (ex_rs1_data >= ex_rs2_data);
      default: ex_taken = 1'b0;
    endcase
  end

  // Train the counter of a resolved branch, saturating at both ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        ctr[IDX_W'(i)] <= CTR_INIT;
      end
    end else if (ex_fire && ex_is_br) begin
      if (ex_taken && (ctr[ex_idx] != CTR_MAX)) begin
        ctr[ex_idx] <= ctr[ex_idx] + CTR_ONE;
      end else if (!ex_taken && (ctr[ex_idx] != '0)) begin
        ctr[ex_idx] <= ctr[ex_idx] - CTR_ONE;
      end
    end
  end

  // Redirect pulse/target and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_valid <= 1'b0;
      redir_addr  <= '0;
      perf_br     <= '0;
      perf_miss   <= '0;
    end else begin
      redir_valid <= 1'b0;
      if (ex_fire && ex_is_jalr) begin
        redir_valid <= 1'b1;
        redir_addr  <= (ex_rs1_data + i_imm(ex_ir)) & ~XLEN'(1);
      end else if (ex_fire && ex_is_br) begin
        perf_br <= perf_br + 32'd1;
        if (ex_miss) begin
          perf_miss   <= perf_miss + 32'd1;
          redir_valid <= 1'b1;
          redir_addr  <= ex_taken ? (ex_pc + b_imm(ex_ir)) : (ex_pc + XLEN'(4));
        end
      end
    end
  end

  // Instruction fields this unit never looks at
  logic unused_bits;
  assign unused_bits = ^{if_ir[24:12], ex_ir[19:15]};

endmodule
